lsu_dmem_ctrl: RTL and testbench
================================

Name: lsu_dmem_ctrl

Overview:
Load/store unit between the core datapath and the word-only data memory (DMEM), which has no byte enables.
- Translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into DMEM word accesses.
- Extracts and sign/zero-extends load data.
- Performs sub-word stores as a two-cycle read-modify-write (RMW), stalling the core during the RMW.
- Flags misaligned, out-of-range and illegal accesses without touching memory.

Parameters:
- DEPTH, 256: DMEM depth in 32-bit words. The legal byte address range is 0 to 4*DEPTH-1. Must be a power of two.
- IDX_W, 8: word index width (log2 DEPTH). DMEM is driven with the word-aligned byte address; DMEM decodes addr[IDX_W+1:2].

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: core issues a memory instruction this cycle.
- req_write, input, 1: 1 = store, 0 = load.
- req_funct3, input, 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data (rs2).
- rdata, output, 32: extended load result.
- done, output, 1: request retires this cycle.
- stall, output, 1: core must hold its PC/pipeline this cycle.
- misaligned, output, 1: alignment fault, pulsed with done.
- access_fault, output, 1: out-of-range or illegal funct3, pulsed with done.
- MemRead, output, 1: to DMEM.
- MemWrite, output, 1: to DMEM.
- mem_addr, output, 32: to DMEM; always word-aligned ({addr[31:2],2'b00}).
- mem_wdata, output, 32: to DMEM WriteData.
- mem_rdata, input, 32: from DMEM ReadData (combinational read).

Behaviour:
- Reset: asynchronous, active-low. State = IDLE; addr_q, merge_q, f3_q cleared. While rst_n = 0, all outputs are 0.
- FSM has two states, IDLE and RMW_WR.
- IDLE with req_valid = 0: all outputs 0.
- IDLE, request checks, in priority order:
  1. Illegal funct3: loads with 011/110/111, stores with funct3 other than 000/001/010. Response: access_fault = 1, done = 1, no MemRead/MemWrite, rdata = 0.
  2. Misaligned: H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] != 0. Response: misaligned = 1, done = 1, no memory strobe, rdata = 0.
  3. Out-of-range: addr >= 4*DEPTH. Response: access_fault = 1, done = 1, no strobe, rdata = 0.
- IDLE, legal load (single cycle, combinational):
  - MemRead = 1, mem_addr = aligned address, done = 1, stall = 0.
  - Byte = mem_rdata[8*addr[1:0] +: 8]; halfword = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- IDLE, legal SW (single cycle): MemWrite = 1, mem_wdata = req_wdata, done = 1. DMEM commits at that clock edge.
- IDLE, legal SB/SH, RMW cycle 1 (read):
  - MemRead = 1, stall = 1, done = 0.
  - merge_q <= mem_rdata with the target lane(s) replaced by req_wdata[7:0] or [15:0]. Little-endian lane = addr[1:0] for bytes, addr[1] for halfwords.
  - addr_q <= aligned address. Next state RMW_WR.
- RMW_WR, RMW cycle 2 (write):
  - MemWrite = 1, mem_addr = addr_q, mem_wdata = merge_q, done = 1, stall = 0. Next state IDLE.
  - Request inputs are ignored in this state; the core holds them because stall was 1.
- Latency: loads, SW and faults take 1 cycle; SB/SH take 2 cycles.
- MemRead and MemWrite are never asserted together.
- mem_wdata = 0 whenever MemWrite = 0.
- Reset asserted during RMW_WR: the write is dropped, the memory word is unchanged, and the FSM returns to IDLE.
- Back-to-back: a new request is accepted in IDLE the cycle after RMW_WR. For example, SB followed immediately by LB to the same address returns the merged byte.

Test Plan:
- Reset, then idle: all outputs 0 and state IDLE.
- Preload word 4 = 0x8081_F0A5. Load results and response:
  - LB @0x10 → 0xFFFF_FFA5.
  - LBU @0x11 → 0x0000_00F0.
  - LH @0x12 → 0xFFFF_8081.
  - LHU @0x12 → 0x0000_8081.
  - Each completes in 1 cycle with done = 1 and stall = 0.
- SB 0x5A @0x13 onto 0x1122_3344:
  - Cycle 1: stall = 1, MemRead = 1.
  - Cycle 2: MemWrite = 1, mem_wdata = 0x5A22_3344.
  - Memory word reads back 0x5A22_3344.
- SH 0xBEEF @0x22 onto 0xAAAA_AAAA → 0xBEEF_AAAA in 2 cycles. An immediately following LW @0x20 returns 0xBEEF_AAAA.
- Fault cases, each with done = 1, no strobes, rdata = 0 and memory unchanged:
  - LW @0x0000_0002 → misaligned.
  - SH @0x0000_0005 → misaligned.
  - LW @0x0000_0400 (DEPTH = 256) → access_fault.
  - funct3 = 011 load → access_fault.
- SB started, then rst_n pulled low during RMW_WR: no MemWrite seen, original word intact, FSM back in IDLE, all outputs 0.

Source files
------------

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit in front of a word-only data memory without byte enables.
// Loads and SW complete in one cycle; SB/SH use a two-cycle read-modify-write
// that stalls the core. Faulting requests retire without touching memory.
module lsu_dmem_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        misaligned,
  output logic        access_fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    S_IDLE,
    S_RMW_WR
  } state_t;

  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  state_t      r_state;
  logic [31:0] r_addr_q;
  logic [31:0] r_merge_q;
  logic [2:0]  r_f3_q;

  logic        w_illegal;
  logic        w_misal;
  logic        w_oor;
  logic        w_legal;
  logic        w_subword_st;
  logic [31:0] w_aligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge;

  // Request classification: illegal funct3, alignment and range checks.
  always_comb begin
    w_aligned = {req_addr[31:2], 2'b00};
    if (req_write) begin
      w_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end else begin
      w_illegal = (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    end
    w_misal      = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_oor        = ({1'b0, req_addr} >= LIMIT);
    w_legal      = !w_illegal && !w_misal && !w_oor;
    w_subword_st = req_write && (req_funct3 != 3'b010);
  end

  // Load lane extraction with sign/zero extension, and sub-word store merge.
  always_comb begin
    w_byte = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    w_half = mem_rdata[{req_addr[1], 4'b0000} +: 16];
    case (req_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'b0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'b0, w_half};
      default: w_load_data = mem_rdata;
    endcase
    w_merge = mem_rdata;
    if (req_funct3[1:0] == 2'b00) begin
      w_merge[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    end else begin
      w_merge[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end
  end

  // Response and DMEM strobes; everything is held at zero while in reset.
  always_comb begin
    rdata        = '0;
    done         = 1'b0;
    stall        = 1'b0;
    misaligned   = 1'b0;
    access_fault = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_illegal) begin
              access_fault = 1'b1;
              done         = 1'b1;
            end else if (w_misal) begin
              misaligned = 1'b1;
              done       = 1'b1;
            end else if (w_oor) begin
              access_fault = 1'b1;
              done         = 1'b1;
            end else if (!req_write) begin
              MemRead  = 1'b1;
              mem_addr = w_aligned;
              rdata    = w_load_data;
              done     = 1'b1;
            end else if (!w_subword_st) begin
              MemWrite  = 1'b1;
              mem_addr  = w_aligned;
              mem_wdata = req_wdata;
              done      = 1'b1;
            end else begin
              MemRead  = 1'b1;
              mem_addr = w_aligned;
              stall    = 1'b1;
            end
          end
        end
        S_RMW_WR: begin
          MemWrite  = 1'b1;
          mem_addr  = r_addr_q;
          mem_wdata = r_merge_q;
          done      = 1'b1;
        end
      endcase
    end
  end

  // RMW sequencing: capture the merged word on the read cycle, write it next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr_q  <= '0;
      r_merge_q <= '0;
      r_f3_q    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && w_legal && w_subword_st) begin
            r_merge_q <= w_merge;
            r_addr_q  <= w_aligned;
            r_f3_q    <= req_funct3;
            r_state   <= S_RMW_WR;
          end
        end
        S_RMW_WR: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Only in-range SB/SH requests may reach the write half of the RMW.
  a_rmw_ok: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_RMW_WR) |-> ((r_f3_q[2:1] == 2'b00) && (r_addr_q[31:IDX_W+2] == '0)));

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl with a word-only DMEM model behind it.
module tb_lsu_dmem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LIMIT = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        misaligned;
  logic        access_fault;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.DEPTH(DEPTH), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .done(done), .stall(stall), .misaligned(misaligned),
    .access_fault(access_fault), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DMEM model: combinational read, write on rising edge, plus backdoor load.
  logic [31:0] dmem [0:255];
  logic        bd_fill;
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  function automatic logic [31:0] pat(int unsigned i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = dmem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 256; i++) dmem[i] <= pat(i);
    end else if (MemWrite) begin
      dmem[mem_addr[9:2]] <= mem_wdata;
    end else if (bd_we) begin
      dmem[bd_idx] <= bd_data;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state and scoreboard queues.
  typedef struct {
    logic [31:0] rdata;
    bit          chk_rd;
    bit          mis;
    bit          af;
    bit          load;
    int unsigned done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] ref_mem [0:255];
  exp_t        exp_q[$];
  wr_t         wr_q[$];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural behaviour of one request, derived from the ISA rules.
  task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e, output int unsigned lat);
    int unsigned size;
    bit          illegal;
    logic [31:0] word;
    logic [31:0] val;
    logic [31:0] mask;
    int unsigned k;
    e = '{rdata: 32'h0, chk_rd: 1'b0, mis: 1'b0, af: 1'b0, load: 1'b0, done_cyc: 0};
    lat = 1;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (illegal) begin
      e.af = 1'b1; e.chk_rd = 1'b1;
    end else if ((addr % size) != 0) begin
      e.mis = 1'b1; e.chk_rd = 1'b1;
    end else if (addr >= LIMIT) begin
      e.af = 1'b1; e.chk_rd = 1'b1;
    end else if (!wr) begin
      word = ref_mem[addr >> 2];
      val = word >> (8 * (addr % 4));
      if (size == 1) begin
        val = val & 32'hFF;
        if (!f3[2] && val >= 32'd128) val = val + 32'hFFFF_FF00;
      end else if (size == 2) begin
        val = val & 32'hFFFF;
        if (!f3[2] && val >= 32'd32768) val = val + 32'hFFFF_0000;
      end
      e.load = 1'b1; e.chk_rd = 1'b1; e.rdata = val;
    end else begin
      word = ref_mem[addr >> 2];
      for (int unsigned i = 0; i < size; i++) begin
        k = (addr % 4) + i;
        mask = 32'hFF << (8 * k);
        word = (word & ~mask) | (((wd >> (8 * i)) & 32'hFF) << (8 * k));
      end
      ref_mem[addr >> 2] = word;
      wr_q.push_back('{addr: addr & 32'hFFFF_FFFC, data: word});
      lat = (size == 4) ? 1 : 2;
    end
  endtask

  // Monitor: pops expectations whenever the DUT retires or writes memory.
  task automatic monitor();
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'h0);
        if (!MemWrite) chk("wdata_when_no_write", mem_wdata, 32'h0);
        if (stall) begin
          chk("stall_memread", {31'b0, MemRead}, 32'h1);
          chk("stall_done", {31'b0, done}, 32'h0);
        end
        if (MemWrite) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", 32'h1, 32'h0);
          end else begin
            w = wr_q.pop_front();
            chk("write_addr", mem_addr, w.addr);
            chk("write_data", mem_wdata, w.data);
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            chk("access_fault", {31'b0, access_fault}, {31'b0, e.af});
            chk("stall_at_done", {31'b0, stall}, 32'h0);
            chk("latency_cycle", cyc, e.done_cyc);
            if (e.chk_rd) chk("rdata", rdata, e.rdata);
            if (e.mis || e.af) chk("fault_strobes", {30'b0, MemRead, MemWrite}, 32'h0);
            else if (e.load) chk("load_memread", {31'b0, MemRead}, 32'h1);
          end
        end
      end
    end
  endtask

  // Driver helpers: each starts 1 time unit after a rising edge.
  task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t        e;
    int unsigned lat;
    model(wr, f3, addr, wd, e, lat);
    e.done_cyc = cyc + lat - 1;
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    repeat (lat) @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle1();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int unsigned idx, input logic [31:0] val);
    bd_we = 1'b1; bd_idx = 8'(idx); bd_data = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return rdata | mem_addr | mem_wdata |
           {26'b0, done, stall, misaligned, access_fault, MemRead, MemWrite};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned bad;
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned sz;
    rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h0;
    bd_fill = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    fork monitor(); join_none

    // Reset held with a request pending: outputs must stay quiet.
    @(negedge clk);
    chk("reset_outputs", all_outs(), 32'h0);
    @(posedge clk); #1;
    bd_fill = 1'b0; req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 32'h0);
    @(posedge clk); #1;

    // Load extraction.
    preload(4, 32'h8081_F0A5);
    issue(0, 3'b000, 32'h10, 0);
    issue(0, 3'b100, 32'h11, 0);
    issue(0, 3'b001, 32'h12, 0);
    issue(0, 3'b101, 32'h12, 0);
    issue(0, 3'b010, 32'h10, 0);

    // Sub-word stores and back-to-back readback.
    preload(4, 32'h1122_3344);
    issue(1, 3'b000, 32'h13, 32'hFFFF_FF5A);
    issue(0, 3'b000, 32'h13, 0);
    issue(0, 3'b010, 32'h10, 0);
    preload(8, 32'hAAAA_AAAA);
    issue(1, 3'b001, 32'h22, 32'h1234_BEEF);
    issue(0, 3'b010, 32'h20, 0);
    issue(1, 3'b010, 32'h30, 32'hDEAD_BEEF);
    issue(0, 3'b101, 32'h30, 0);

    // Faults and range boundary.
    issue(0, 3'b010, 32'h2, 0);
    issue(1, 3'b001, 32'h5, 32'h1234);
    issue(0, 3'b010, 32'h400, 0);
    issue(0, 3'b011, 32'h10, 0);
    issue(1, 3'b100, 32'h10, 32'h77);
    issue(0, 3'b010, 32'h3FC, 0);
    issue(1, 3'b000, 32'h3FF, 32'h99);
    issue(0, 3'b000, 32'h3FF, 0);
    issue(1, 3'b000, 32'h400, 32'h99);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      f3 = 3'($urandom_range(0, 7));
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      case ($urandom_range(0, 15))
        0:       a = $urandom;
        1, 2:    a = 32'($urandom_range(LIMIT, LIMIT + 64));
        default: a = 32'($urandom_range(0, LIMIT - 1));
      endcase
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      issue(1'($urandom_range(0, 1)), f3, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle1();
    end

    // Reset during the write half of an RMW drops the write.
    preload(5, 32'hCAFE_F00D);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h15; req_wdata = 32'h77;
    @(posedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmw_reset_outputs", all_outs(), 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_reset_word", dmem[5], 32'hCAFE_F00D);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmw_reset_idle", all_outs(), 32'h0);
    @(posedge clk); #1;
    issue(0, 3'b010, 32'h14, 0);
    issue(1, 3'b000, 32'h15, 32'h3C);
    issue(0, 3'b100, 32'h15, 0);

    repeat (3) idle1();
    chk("exp_q_drained", exp_q.size(), 32'h0);
    chk("wr_q_drained", wr_q.size(), 32'h0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) bad++;
    chk("final_memory_words_bad", bad, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
